// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of high cycles in a period of n; odd divisors get the extra cycle high.
  function automatic int unsigned high_cycles(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: walks 0..div-1 and produces the registered clk_out/tick pair.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         active,
  input  logic         run_next,
  input  logic [W-1:0] div,
  output logic         clk_out,
  output logic         tick,
  output logic         boundary
);

  typedef logic [W-1:0] cnt_t;

  cnt_t cnt;
  cnt_t cnt_next;
  cnt_t high;

  assign high     = cnt_t'(high_cycles(32'(div)));
  assign boundary = active && (cnt == div - cnt_t'(1));

  // Entering RUN from IDLE and wrapping at the boundary both restart at 0.
  always_comb begin
    cnt_next = '0;
    if (run_next && active && !boundary) begin
      cnt_next = cnt + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_out <= run_next && (cnt_next < high);
      tick    <= run_next && (cnt_next == '0);
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: run/idle FSM, divisor staging and error pulse.
//   state | meaning
//   IDLE  | stopped, clk_out low, divisor loads apply directly
//   RUN   | dividing; en low or new divisor only honoured at period boundary
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         div_load,
  input  logic [W-1:0] div_val,
  output logic         clk_out,
  output logic         tick,
  output logic         running,
  output logic         div_pending,
  output logic         div_err,
  output logic [W-1:0] div_cur
);

  typedef logic [W-1:0] dval_t;

  localparam dval_t RESET_DIV = dval_t'(DEFAULT_DIV);

  if (DEFAULT_DIV < 1 || DEFAULT_DIV > (2 ** W) - 1) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV out of range 1..2^W-1");
  end

  state_t state;
  state_t state_next;
  dval_t  pend_val;
  logic   boundary;
  logic   run_next;
  logic   load_ok;

  assign load_ok  = div_load && (div_val != '0);
  assign running  = (state == RUN);
  assign run_next = (state_next == RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (boundary && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A load landing on a boundary (or in IDLE) goes straight to div_cur and wins over any staged value.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      div_cur     <= RESET_DIV;
      pend_val    <= '0;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      state   <= state_next;
      div_err <= div_load && (div_val == '0);
      if (state == IDLE || boundary) begin
        if (load_ok) begin
          div_cur     <= div_val;
          div_pending <= 1'b0;
        end else if (div_pending) begin
          div_cur     <= pend_val;
          div_pending <= 1'b0;
        end
      end else if (load_ok) begin
        pend_val    <= div_val;
        div_pending <= 1'b1;
      end
    end
  end

  clk_div_counter #(
    .W(W)
  ) u_counter (
    .clk_in   (clk_in),
    .rst      (rst),
    .active   (running),
    .run_next (run_next),
    .div      (div_cur),
    .clk_out  (clk_out),
    .tick     (tick),
    .boundary (boundary)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, hand sequences, random run vs model.
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_val = '0;
  logic       clk_out, tick, running, div_pending, div_err;
  logic [7:0] div_cur;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(.W(8), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .div_load    (div_load),
    .div_val     (div_val),
    .clk_out     (clk_out),
    .tick        (tick),
    .running     (running),
    .div_pending (div_pending),
    .div_err     (div_err),
    .div_cur     (div_cur)
  );

  typedef struct {
    logic       r, e, l;
    logic [7:0] v;
    logic       co, tk, rn, pd, er;
    logic [7:0] dv;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, e, l, input logic [7:0] v,
                     input logic co, tk, rn, pd, er, input logic [7:0] dv);
    vec_t x;
    x = '{r, e, l, v, co, tk, rn, pd, er, dv};
    vt.push_back(x);
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, l, input logic [7:0] v);
    @(negedge clk_in);
    rst = r; en = e; div_load = l; div_val = v;
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic co, tk, rn, pd, er,
                            input logic [7:0] dv);
    chk({tag, ".clk_out"}, int'(clk_out), int'(co));
    chk({tag, ".tick"}, int'(tick), int'(tk));
    chk({tag, ".running"}, int'(running), int'(rn));
    chk({tag, ".div_pending"}, int'(div_pending), int'(pd));
    chk({tag, ".div_err"}, int'(div_err), int'(er));
    chk({tag, ".div_cur"}, int'(div_cur), int'(dv));
  endtask

  // Reference model: position within the current period plus divisor bookkeeping.
  int m_run, m_pos, m_n, m_pv, m_pval, m_err;

  task automatic model_step(input logic r, e, l, input logic [7:0] v);
    int ok;
    if (r) begin
      m_run = 0; m_pos = 0; m_n = 4; m_pv = 0; m_pval = 0; m_err = 0;
      return;
    end
    m_err = (l && v == 0) ? 1 : 0;
    ok = (l && v != 0) ? 1 : 0;
    if (m_run == 0) begin
      if (ok != 0) begin m_n = v; m_pv = 0; end
      else if (m_pv != 0) begin m_n = m_pval; m_pv = 0; end
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == m_n - 1) begin
      if (ok != 0) begin m_n = v; m_pv = 0; end
      else if (m_pv != 0) begin m_n = m_pval; m_pv = 0; end
      m_pos = 0;
      m_run = e ? 1 : 0;
    end else begin
      m_pos++;
      if (ok != 0) begin m_pval = v; m_pv = 1; end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // rst en ld val | clk tick run pend err div
    add(1,0,0,0,  0,0,0,0,0,4);
    add(0,1,0,0,  1,1,1,0,0,4);
    add(0,1,0,0,  1,0,1,0,0,4);
    add(0,1,0,0,  0,0,1,0,0,4);
    add(0,1,0,0,  0,0,1,0,0,4);
    add(0,1,0,0,  1,1,1,0,0,4);
    add(0,1,0,0,  1,0,1,0,0,4);
    add(0,1,1,5,  0,0,1,1,0,4);
    add(0,1,0,0,  0,0,1,1,0,4);
    add(0,1,0,0,  1,1,1,0,0,5);
    add(0,1,0,0,  1,0,1,0,0,5);
    add(0,1,0,0,  1,0,1,0,0,5);
    add(0,1,0,0,  0,0,1,0,0,5);
    add(0,1,0,0,  0,0,1,0,0,5);
    add(0,1,0,0,  1,1,1,0,0,5);
    add(0,1,1,0,  1,0,1,0,1,5);
    add(0,1,0,0,  1,0,1,0,0,5);
    add(0,1,1,6,  0,0,1,1,0,5);
    add(0,1,1,3,  0,0,1,1,0,5);
    add(0,1,0,0,  1,1,1,0,0,3);
    add(0,1,0,0,  1,0,1,0,0,3);
    add(0,1,0,0,  0,0,1,0,0,3);
    add(0,1,0,0,  1,1,1,0,0,3);
    add(0,1,0,0,  1,0,1,0,0,3);
    add(0,1,0,0,  0,0,1,0,0,3);
    add(0,1,1,4,  1,1,1,0,0,4);
    add(0,0,0,0,  1,0,1,0,0,4);
    add(0,0,0,0,  0,0,1,0,0,4);
    add(0,0,0,0,  0,0,1,0,0,4);
    add(0,0,0,0,  0,0,0,0,0,4);
    add(0,0,0,0,  0,0,0,0,0,4);
    add(0,1,0,0,  1,1,1,0,0,4);
    add(0,1,1,1,  1,0,1,1,0,4);
    add(0,1,0,0,  0,0,1,1,0,4);
    add(0,1,0,0,  0,0,1,1,0,4);
    add(0,1,0,0,  1,1,1,0,0,1);
    add(0,1,0,0,  1,1,1,0,0,1);
    add(0,1,0,0,  1,1,1,0,0,1);
    add(0,1,1,6,  1,1,1,0,0,6);
    add(0,1,0,0,  1,0,1,0,0,6);
    add(0,1,1,7,  1,0,1,1,0,6);
    add(1,1,0,0,  0,0,0,0,0,4);
    add(1,1,1,9,  0,0,0,0,0,4);
    add(0,1,0,0,  1,1,1,0,0,4);

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].e, vt[i].l, vt[i].v);
      expect_all($sformatf("vec%0d", i), vt[i].co, vt[i].tk, vt[i].rn,
                 vt[i].pd, vt[i].er, vt[i].dv);
    end

    // IDLE load, one-cycle start latency, and an en dip that must not cut the period.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 9);
    expect_all("idle_load", 0, 0, 0, 0, 0, 9);
    drive(0, 1, 0, 0);
    expect_all("start9", 1, 1, 1, 0, 0, 9);
    for (int i = 1; i <= 8; i++) begin
      drive(0, (i == 2 || i == 3) ? 1'b0 : 1'b1, 0, 0);
      chk($sformatf("dip%0d.running", i), int'(running), 1);
      chk($sformatf("dip%0d.tick", i), int'(tick), 0);
      chk($sformatf("dip%0d.clk_out", i), int'(clk_out), (i < 5) ? 1 : 0);
    end
    drive(0, 1, 0, 0);
    expect_all("dip_wrap", 1, 1, 1, 0, 0, 9);

    // Randomised run against the model.
    drive(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, e, l;
      logic [7:0] v;
      int sel;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0) v = 8'd0;
      else if (sel == 1) v = 8'($urandom_range(1, 40));
      else v = 8'($urandom_range(1, 8));
      drive(r, e, l, v);
      model_step(r, e, l, v);
      expect_all($sformatf("rnd%0d", c),
                 (m_run != 0) && (m_pos < (m_n + 1) / 2),
                 (m_run != 0) && (m_pos == 0),
                 m_run != 0, m_pv != 0, m_err != 0, 8'(m_n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
